serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new addition; sampled only while busy=0.
REQ-005 a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007 ci  input  1  carry-in, captured on the accepted start edge.
REQ-008 s  output  WIDTH  registered sum.
REQ-009 co  output  1  registered carry-out.
REQ-010 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-011 done  output  1  one-cycle pulse marking s/co valid.

Function
REQ-012 The block SHALL compute {co,s} = a + b + ci with exactly one 1-bit full-adder slice per cycle, processing bits LSB first.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 IDLE: start=1 SHALL capture a, b and ci into internal shift and carry registers, clear the bit counter and go to SHIFT; start=0 SHALL keep IDLE.
REQ-015 SHIFT, each cycle: sum bit = A[0]^B[0]^carry; carry <= A[0]&B[0] | (A[0]^B[0])&carry; A and B shift right by one; the sum bit shifts into the result MSB; counter increments.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL load s and co and move to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH, and busy SHALL go low after edge k+WIDTH+1.
REQ-019 start while busy=1, including in DONE, SHALL be ignored and SHALL NOT disturb operands, counter or outputs.
REQ-020 Changes on a, b or ci after the capture edge SHALL NOT affect the result.
REQ-021 s and co SHALL hold their last result from DONE until the next operation's DONE. They SHALL NOT change during SHIFT.
REQ-022 Wrap-around: the carry out of bit WIDTH-1 SHALL appear only on co; s SHALL be the sum modulo 2^WIDTH.

Reset
REQ-023 With reset=1 at a rising edge: state <= IDLE, counter <= 0, internal registers <= 0, s <= 0, co <= 0, busy = 0, done = 0.
REQ-024 Reset SHALL take priority over start and over every state, including mid-SHIFT. The aborted operation SHALL produce no done pulse.
REQ-025 A start that is high on the same edge as reset SHALL be ignored.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN: when defined, the block SHALL add input sub (1 bit), captured with the operands.
REQ-027 With sub=1, the block SHALL compute a + ~b + 1: it inverts B at capture and forces the captured carry-in to 1, ignoring ci. co=1 then means no borrow.
REQ-028 With sub=0, or without the macro, the behaviour SHALL be exactly that of REQ-012..022. Without the macro, the sub port SHALL NOT exist.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, ci=0, start pulsed at edge k -> s=0x96, co=0, done high only in the cycle after edge k+8, busy low after edge k+9.
REQ-030 a=0xFF, b=0x01, ci=0 -> s=0x00, co=1. Then a=0xFF, b=0xFF, ci=1 -> s=0xFF, co=1.
REQ-031 Start 0x12+0x34, then pulse start again with a=0xFF, b=0xFF at edge k+3 -> second start ignored; s=0x46, co=0, exactly one done pulse.
REQ-032 Start an operation, assert reset at edge k+4 -> busy=0, s=0x00, co=0 next cycle, no done; a fresh start then completes normally.
REQ-033 SERIAL_ADDER_SUB_EN defined, sub=1, a=0x10, b=0x01 -> s=0x0F, co=1. With a=0x01, b=0x02 -> s=0xFF, co=0.
REQ-034 Random a, b, ci over 1000 operations with random start gaps, including back-to-back starts on the first IDLE cycle -> {co,s} matches a reference model every time.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice per cycle, LSB first, IDLE/SHIFT/DONE control.
// Optional subtract mode (input sub) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   s_q;
  logic               co_q;
  logic               busy_q;
  logic               done_q;

  logic               sum_bit_d;
  logic               carry_d;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   b_cap_d;
  logic               ci_cap_d;

  // Subtract mode: capture ~b with a forced carry-in of 1 (a + ~b + 1)
`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap_d  = sub ? ~b : b;
  assign ci_cap_d = sub ? 1'b1 : ci;
`else
  assign b_cap_d  = b;
  assign ci_cap_d = ci;
`endif

  // One full-adder slice on the current LSBs; sum bit enters the result MSB
  assign sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_d   = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
  assign res_d     = {sum_bit_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b_cap_d;
            carry_q <= ci_cap_d;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Last slice publishes the result in the same edge
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            s_q     <= res_d;
            co_q    <= carry_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus randomized
// operations against an arithmetic reference model. Define SERIAL_ADDER_SUB_EN for sub mode.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic [W-1:0] s;
  logic         co;
  logic         busy;
  logic         done;

  int n_tests;
  int n_fail;

  logic [W-1:0] prev_s;
  logic         prev_co;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .ci    (ci),
    .s     (s),
    .co    (co),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {co,s} as plain integer arithmetic on the operands
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mci, input logic msub);
    int unsigned r;
    if (msub) r = int'(ma) + int'((~mb) & 8'hFF) + 1;
    else      r = int'(ma) + int'(mb) + int'(mci);
    return (W+1)'(r);
  endfunction

  // Called at a negedge; runs one operation and checks timing and result.
  // inj: extra start pulse (with junk operands) for edge k+inj; noise: random starts while busy.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                       input logic osub, input int inj, input bit noise);
    logic [W:0] exp;
    logic       bsub;
`ifdef SERIAL_ADDER_SUB_EN
    bsub = osub;
`else
    bsub = 1'b0;
`endif
    exp   = model(oa, ob, oci, bsub);
    start = 1'b1;
    a     = oa;
    b     = ob;
    ci    = oci;
    sub   = osub;
    @(negedge clk);  // edge k captured
    for (int i = 0; i <= int'(W); i++) begin
      int j;
      j = i + 1;
      start = ((j == inj) || (noise && ($urandom_range(0, 2) == 0))) ? 1'b1 : 1'b0;
      a     = (j == inj) ? 8'hFF : W'($urandom);
      b     = (j == inj) ? 8'hFF : W'($urandom);
      ci    = 1'($urandom);
      sub   = 1'($urandom);
      @(negedge clk);  // edge k+j
      check("done", 32'(done), 32'(j == int'(W)));
      check("busy", 32'(busy), 32'(j <= int'(W)));
      if (j < int'(W)) begin
        check("s_hold", 32'(s), 32'(prev_s));
        check("co_hold", 32'(co), 32'(prev_co));
      end else begin
        check("s", 32'(s), 32'(exp[W-1:0]));
        check("co", 32'(co), 32'(exp[W]));
      end
    end
    start   = 1'b0;
    prev_s  = exp[W-1:0];
    prev_co = exp[W];
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    prev_s  = '0;
    prev_co = 1'b0;
    reset   = 1'b1;
    start   = 1'b0;
    sub     = 1'b0;
    a       = '0;
    b       = '0;
    ci      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s", 32'(s), 32'h0);
    check("rst_co", 32'(co), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, -1, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1, 1'b0);
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 1'b0);
    // start also pulsed while in DONE
    do_op(8'h00, 8'h00, 1'b0, 1'b0, int'(W) + 1, 1'b0);

    // Reset mid-shift at edge k+4: operation aborted, no done pulse
    start = 1'b1; a = 8'hA5; b = 8'h77; ci = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_s", 32'(s), 32'h0);
    check("abort_co", 32'(co), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'h0);
    end
    prev_s  = '0;
    prev_co = 1'b0;
    do_op(8'h80, 8'h80, 1'b1, 1'b0, -1, 1'b0);

    // start coincident with reset is ignored
    reset = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check("rst_start_busy2", 32'(busy), 32'h0);
    check("rst_start_s", 32'(s), 32'h0);
    prev_s  = '0;
    prev_co = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, -1, 1'b0);
    do_op(8'h01, 8'h02, 1'b1, 1'b1, -1, 1'b0);
`endif

    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
      repeat (gap) @(negedge clk);
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            -1, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
